// File: rtl/sync_updown_counter.sv
// Synchronous up/down modulo counter with load, clear, wrap/saturate mode,
// a combinational terminal-count flag, a one-cycle wrap pulse and a sticky overflow flag.
module sync_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  // Reject configurations that cannot be represented in WIDTH bits.
  generate
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("sync_updown_counter: MODULUS out of range");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
      $error("sync_updown_counter: SATURATE must be 0 or 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             ovf_nxt;

  assign at_top = (count == MAX_VAL);
  assign at_bot = (count == '0);
  assign tc     = in & ~clr & ~load & ((up & at_top) | (~up & at_bot));

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    ovf_nxt   = ovf;
    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
    end else if (load) begin
      count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (in) begin
      if (up) begin
        if (!at_top) begin
          count_nxt = count + WIDTH'(1);
        end else begin
          ovf_nxt = 1'b1;
          if (SATURATE == 0) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end
        end
      end else begin
        if (!at_bot) begin
          count_nxt = count - WIDTH'(1);
        end else begin
          ovf_nxt = 1'b1;
          if (SATURATE == 0) begin
            count_nxt = MAX_VAL;
            wrap_nxt  = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule
